mem_port_arbiter: RTL

Shares the single unified memory port between instruction fetch (IF) and the data access issued from the EX/ME pipeline register (ME). It sequences each access as a request/acknowledge transaction, generates byte enables and lane-aligned store data, sign/zero-extends load data, and drives a pipeline stall while any accepted or pending access is incomplete. ME accesses take priority over IF because they belong to the older instruction.

---
 rtl/rv32_mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the unified memory port: access lengths, arbiter
// states and byte-enable patterns.
package rv32_mem_pkg;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_ME = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data,
// load byte/half selection with extension, and alignment check.
module mem_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  len_i,
  input  logic [1:0]  addr_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_ext_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o        = BE_ALL;
    wdata_rep_o = wdata_i;
    rdata_ext_o = rdata_i;
    misalign_o  = 1'b0;
    case (len_i)
      LEN_B: begin
        be_o        = BE_BYTE << addr_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      LEN_H: begin
        be_o        = BE_HALF << {addr_i[1], 1'b0};
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_ext_o = {{16{~uns_i & half_sel[15]}}, half_sel};
        misalign_o  = addr_i[0];
      end
      // 2'b11 behaves exactly like a word access
      default: misalign_o = |addr_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// EX/ME data access (data first), one request/ack transaction at a time.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              me_r,
  input  logic              me_w,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [31:0]       me_wdata,
  input  logic [1:0]        me_len,
  input  logic              me_uns,
  output logic [31:0]       me_rdata,
  output logic              me_ready,
  output logic              me_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        len_q, len_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_me_q, owner_me_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       resp_q, resp_d;

  logic        me_any;
  logic        idle;
  logic        busy;
  logic [1:0]  lane_len;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata_rep;
  logic [31:0] lane_rdata_ext;
  logic        lane_misalign;

  assign me_any = me_r | me_w;
  assign idle   = (state_q == ST_IDLE);
  assign busy   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_ME);

  // In IDLE the aligner checks the live ME request so a misaligned access
  // can answer one cycle later; while busy it works from the latched copy.
  assign lane_len  = idle ? me_len : len_q;
  assign lane_addr = idle ? me_addr[1:0] : addr_q[1:0];

  mem_lane_align u_lane (
    .len_i       (lane_len),
    .addr_i      (lane_addr),
    .uns_i       (uns_q),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .be_o        (lane_be),
    .wdata_rep_o (lane_wdata_rep),
    .rdata_ext_o (lane_rdata_ext),
    .misalign_o  (lane_misalign)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_me_d = owner_me_q;
    misalign_d = misalign_q;
    resp_d     = resp_q;
    case (state_q)
      ST_IDLE: begin
        misalign_d = 1'b0;
        if (me_any) begin
          addr_d     = me_addr;
          len_d      = me_len;
          uns_d      = me_uns;
          wdata_d    = me_wdata;
          we_d       = me_w;
          owner_me_d = 1'b1;
          if (lane_misalign) begin
            misalign_d = 1'b1;
            resp_d     = '0;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_BUSY_ME;
          end
        end else if (if_req) begin
          addr_d     = if_addr;
          len_d      = LEN_W;
          uns_d      = 1'b0;
          wdata_d    = '0;
          we_d       = 1'b0;
          owner_me_d = 1'b0;
          state_d    = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_ME: begin
        if (mem_ack) begin
          resp_d  = lane_rdata_ext;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= LEN_B;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_me_q <= 1'b0;
      misalign_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_me_q <= owner_me_d;
      misalign_q <= misalign_d;
      resp_q     <= resp_d;
    end
  end

  assign mem_req     = busy;
  assign mem_we      = busy & we_q;
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be      = busy ? (we_q ? lane_be : BE_ALL) : BE_NONE;
  assign mem_wdata   = (busy & we_q) ? lane_wdata_rep : '0;

  assign if_ready    = (state_q == ST_RESP) & ~owner_me_q;
  assign me_ready    = (state_q == ST_RESP) & owner_me_q;
  assign me_misalign = me_ready & misalign_q;
  assign if_rdata    = resp_q;
  assign me_rdata    = resp_q;

  assign stall = (if_req & ~if_ready) | (me_any & ~me_ready);

endmodule
